// File: rtl/muldiv.sv
// ============================================================================
// muldiv : iterative MIPS-style HI/LO multiply/divide unit (shift-add / restoring divide)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;

  logic             signed_op;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] mult_hi;
  logic [WIDTH-1:0] mult_lo;
  logic [WIDTH:0]   shifted;
  logic             sub_ok;
  logic [WIDTH-1:0] sub_val;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand conditioning: signed ops work on magnitudes, signs fixed up at the end
  always_comb begin
    signed_op = ~op[0];
    mag_a     = (signed_op && a[WIDTH-1]) ? (-a) : a;
    mag_b     = (signed_op && b[WIDTH-1]) ? (-b) : b;
  end

  // One multiply step: {carry, work_hi + mcand, work_lo} shifted right by one
  always_comb begin
    add_sum = {1'b0, work_hi_q} + {1'b0, divisor_q};
    if (work_lo_q[0]) begin
      mult_hi = add_sum[WIDTH:1];
      mult_lo = {add_sum[0], work_lo_q[WIDTH-1:1]};
    end else begin
      mult_hi = {1'b0, work_hi_q[WIDTH-1:1]};
      mult_lo = {work_hi_q[0], work_lo_q[WIDTH-1:1]};
    end
  end

  // One restoring divide step; remainder in work_hi, dividend/quotient in work_lo
  always_comb begin
    shifted = {work_hi_q, work_lo_q[WIDTH-1]};
    sub_ok  = (shifted >= {1'b0, divisor_q});
    sub_val = shifted[WIDTH-1:0] - divisor_q;
    div_hi  = sub_ok ? sub_val : shifted[WIDTH-1:0];
    div_lo  = {work_lo_q[WIDTH-2:0], sub_ok};
  end

  always_comb begin
    prod_mag = {work_hi_q, work_lo_q};
    prod_fix = neg_res_q ? (-prod_mag) : prod_mag;
    quo_fix  = neg_res_q ? (-work_lo_q) : work_lo_q;
    rem_fix  = neg_rem_q ? (-work_hi_q) : work_hi_q;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    divisor_d = divisor_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          count_d   = '0;
          busy_d    = 1'b1;
          is_div_d  = op[1];
          neg_res_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = signed_op & a[WIDTH-1];
          div0_d    = op[1] & (b == '0);
          work_hi_d = '0;
          work_lo_d = op[1] ? mag_a : mag_b;
          divisor_d = op[1] ? mag_b : mag_a;
        end else begin
          if (mthi) hi_d = a;
          if (mtlo) lo_d = a;
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          work_hi_d = div_hi;
          work_lo_d = div_lo;
        end else begin
          work_hi_d = mult_hi;
          work_lo_d = mult_lo;
        end
        if (count_q == LAST_CNT) begin
          state_d = S_FINISH;
          count_d = '0;
        end else begin
          count_d = count_q + ONE_CNT;
        end
      end

      S_FINISH: begin
        // A zero divisor leaves the dividend magnitude in work_hi, so rem_fix == a
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = div0_q ? '1 : quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      divisor_q <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      divisor_q <= divisor_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv.sv
// ============================================================================
// tb_muldiv : scoreboard bench for muldiv with directed, hand-computed vectors
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_muldiv;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b1;
  logic             start   = 1'b0;
  logic [1:0]       op      = 2'b00;
  logic [WIDTH-1:0] a       = '0;
  logic [WIDTH-1:0] b       = '0;
  logic             mthi    = 1'b0;
  logic             mtlo    = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  muldiv #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests    = 0;
  int   fails    = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expectation and checks value, latency, busy length
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_cnt = 0;
    end else if (done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_lo"}, lo, e.lo);
        check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
        check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(LAT));
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end
  end

  // Called at a negedge with the DUT in IDLE; returns at the negedge after the accept edge
  task automatic issue(input string name, input bit push, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    if (push) begin
      e.hi   = eh;
      e.lo   = el;
      e.name = name;
      e.cyc  = cyc + 1 + LAT;
      sb.push_back(e);
    end
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom_range(0, 3));
    check({name, "_busy_after_accept"}, {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      if (done) return;
    end
    tests++;
    fails++;
    $display("FAIL %s_timeout: got no done within %0d cycles expected done", name, LAT + 10);
  endtask

  initial begin
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    issue("multu_max", 1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_done("multu_max");
    issue("mult_neg", 1'b1, 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    wait_done("mult_neg");
    issue("multu_same", 1'b1, 2'b01, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB);
    wait_done("multu_same");
    issue("div_neg", 1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done("div_neg");
    issue("divu_100_7", 1'b1, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_done("divu_100_7");
    issue("div_ovf", 1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    wait_done("div_ovf");
    issue("divu_zero", 1'b1, 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    wait_done("divu_zero");

    mthi = 1'b1;
    a    = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo_kept", lo, 32'hFFFF_FFFF);

    mthi = 1'b1;
    mtlo = 1'b1;
    a    = 32'hA5A5_A5A5;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mthilo_hi", hi, 32'hA5A5_A5A5);
    check("mthilo_lo", lo, 32'hA5A5_A5A5);

    mthi = 1'b1;
    issue("multu_with_mthi", 1'b1, 2'b01, 32'd3, 32'd4, 32'd0, 32'd12);
    mthi = 1'b0;
    check("start_beats_mthi_hi", hi, 32'hA5A5_A5A5);
    repeat (10) @(negedge clk);
    check("hold_hi_in_run", hi, 32'hA5A5_A5A5);
    check("hold_lo_in_run", lo, 32'hA5A5_A5A5);
    wait_done("multu_with_mthi");

    issue("divu_run_pulse", 1'b1, 2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF);
    repeat (5) @(negedge clk);
    start = 1'b1;
    mthi  = 1'b1;
    mtlo  = 1'b1;
    op    = 2'b00;
    a     = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    check("run_pulse_hi", hi, 32'd0);
    check("run_pulse_lo", lo, 32'd12);
    wait_done("divu_run_pulse");
    repeat (LAT + 5) @(negedge clk);
    check("after_pulse_hi", hi, 32'hF);

    issue("multu_abort", 1'b0, 2'b01, 32'd7, 32'd9, 32'd0, 32'd63);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    issue("multu_3x4", 1'b1, 2'b01, 32'd3, 32'd4, 32'd0, 32'd12);
    wait_done("multu_3x4");

    repeat (LAT + 5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
